ro_freq_meter: RTL and testbench

Gated edge counter that measures the frequency of a ring-oscillator divider tap against the system clock. It sits directly downstream of the ring-oscillator/ripple-divider stage. It takes one of that stage's divided outputs (e.g. the /16 tap) as an asynchronous input. Each measurement counts the input's rising edges over a fixed window of system-clock cycles and holds the result for readout on the output pins.

---
 rtl/ro_freq_meter.sv | 142 ++++++++++++++
 tb/tb_ro_freq_meter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: gated edge counter that measures a ring-oscillator divider tap
// against the system clock. Each window counts rising edges of osc_in over
// GATE_CYCLES clk cycles and latches the result for readout.
//
// Ports:
//   clk        in   system clock, rising edge; only clock in the block
//   rst        in   asynchronous, active-high reset
//   osc_in     in   divided oscillator tap, asynchronous to clk
//   start      in   single-shot request, sampled on clk (ignored while busy)
//   continuous in   1 = re-arm automatically after each window
//   count      out  edge count of the last completed window
//   valid      out  count holds a completed result (sticky until reset)
//   busy       out  window in progress
//   overflow   out  last completed window saturated the counter
module ro_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ACC_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        StIdle,
        StMeasure
    } state_e;

    state_e              state_q, state_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic                sync1_q, sync2_q, sync3_q;
    logic                edge_pulse;
    logic [CNT_W-1:0]    acc_inc;
    logic                sat_inc;

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= osc_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_pulse = sync2_q & ~sync3_q;

    // Saturating increment; reaching all-ones marks the window as saturated.
    always_comb begin
        acc_inc = acc_q;
        if (edge_pulse && (acc_q != ACC_MAX)) begin
            acc_inc = acc_q + CNT_W'(1);
        end
        sat_inc = sat_q | (acc_inc == ACC_MAX);
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start || continuous) begin
                    state_d = StMeasure;
                    gate_d  = GATE_LOAD;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            StMeasure: begin
                if (gate_q == '0) begin
                    // Last window cycle: publish including this cycle's edge.
                    count_d = acc_inc;
                    ovf_d   = sat_inc;
                    valid_d = 1'b1;
                    if (continuous) begin
                        // Back-to-back re-arm, no dead cycle between windows.
                        gate_d = GATE_LOAD;
                        acc_d  = '0;
                        sat_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gate_d = gate_q - GATE_W'(1);
                    acc_d  = acc_inc;
                    sat_d  = sat_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gate_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == StMeasure);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter. Three instances (different window lengths and
// counter widths) share one stimulus. A window-level reference model, built
// from the recorded osc_in samples, predicts every output every cycle; a
// table of hand-computed vectors and a few hand sequences cover the corners.
module tb_ro_freq_meter;

    localparam int NDUT = 3;
    localparam int G_A  = 100;
    localparam int G_B  = 200;
    localparam int G_C  = 64;
    localparam int W_B  = 4;

    logic clk = 1'b0;
    logic rst;
    logic osc_in;
    logic start;
    logic continuous;

    logic [15:0]    count_a, count_c;
    logic [W_B-1:0] count_b;
    logic valid_a, busy_a, ovf_a;
    logic valid_b, busy_b, ovf_b;
    logic valid_c, busy_c, ovf_c;

    always #5 clk = ~clk;

    ro_freq_meter #(.GATE_CYCLES(G_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
        .count(count_a), .valid(valid_a), .busy(busy_a), .overflow(ovf_a)
    );
    ro_freq_meter #(.GATE_CYCLES(G_B), .CNT_W(W_B)) dut_b (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
        .count(count_b), .valid(valid_b), .busy(busy_b), .overflow(ovf_b)
    );
    ro_freq_meter #(.GATE_CYCLES(G_C), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
        .count(count_c), .valid(valid_c), .busy(busy_c), .overflow(ovf_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: osc_in value seen at each clk edge since reset.
    bit hist[$];
    int g_len[NDUT]   = '{G_A, G_B, G_C};
    int max_cnt[NDUT] = '{65535, 15, 65535};
    bit m_busy[NDUT];
    int m_start[NDUT];
    bit m_valid[NDUT];
    int m_count[NDUT];
    bit m_ovf[NDUT];

    typedef struct {
        string name;
        int    period;
        int    first;
        bit    hold;
        int    exp_a;
        int    exp_b;
        bit    ovf_b;
        int    exp_c;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < NDUT; i++) begin
            m_busy[i]  = 1'b0;
            m_start[i] = 0;
            m_valid[i] = 1'b0;
            m_count[i] = 0;
            m_ovf[i]   = 1'b0;
        end
    endfunction

    // Rising edges whose first-high sample index lies in [lo, hi].
    function automatic int count_rises(input int lo, input int hi);
        int n = 0;
        for (int j = lo; j <= hi; j++) begin
            if (j >= 0 && j < hist.size()) begin
                if (hist[j] && (j == 0 || !hist[j-1])) n++;
            end
        end
        return n;
    endfunction

    task automatic check_all();
        chk("busy_a", busy_a, m_busy[0]);
        chk("valid_a", valid_a, m_valid[0]);
        chk("count_a", count_a, m_count[0]);
        chk("ovf_a", ovf_a, m_ovf[0]);
        chk("busy_b", busy_b, m_busy[1]);
        chk("valid_b", valid_b, m_valid[1]);
        chk("count_b", count_b, m_count[1]);
        chk("ovf_b", ovf_b, m_ovf[1]);
        chk("busy_c", busy_c, m_busy[2]);
        chk("valid_c", valid_c, m_valid[2]);
        chk("count_c", count_c, m_count[2]);
        chk("ovf_c", ovf_c, m_ovf[2]);
    endtask

    // One clk cycle: apply inputs, advance model at the edge, check at negedge.
    // A window started at edge s counts rises sampled at edges s-1 .. s+G-2
    // (three-edge detect latency) and publishes at edge s+G.
    task automatic drive(input bit o, input bit s, input bit c);
        int k;
        int n;
        osc_in     = o;
        start      = s;
        continuous = c;
        @(posedge clk);
        hist.push_back(o);
        k = hist.size() - 1;
        for (int i = 0; i < NDUT; i++) begin
            if (!m_busy[i]) begin
                if (s || c) begin
                    m_busy[i]  = 1'b1;
                    m_start[i] = k;
                end
            end else if (k == m_start[i] + g_len[i]) begin
                n = count_rises(m_start[i] - 1, m_start[i] + g_len[i] - 2);
                m_count[i] = (n > max_cnt[i]) ? max_cnt[i] : n;
                m_ovf[i]   = (n >= max_cnt[i]);
                m_valid[i] = 1'b1;
                if (c) m_start[i] = k;
                else m_busy[i] = 1'b0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic bit osc_val(input vec_t v, input int t);
        if (v.hold) return 1'b1;
        if (t < v.first) return 1'b0;
        return ((t - v.first) % v.period) < (v.period / 2);
    endfunction

    // Single-shot window starting at t=0; optional second start at restart_at.
    task automatic run_vec(input vec_t v, input int restart_at);
        int busy_cyc[NDUT];
        for (int i = 0; i < NDUT; i++) busy_cyc[i] = 0;
        for (int t = -5; t <= 204; t++) begin
            drive(osc_val(v, t), (t == 0) || (t == restart_at), 1'b0);
            if (busy_a) busy_cyc[0]++;
            if (busy_b) busy_cyc[1]++;
            if (busy_c) busy_cyc[2]++;
        end
        chk({v.name, ":count_a"}, count_a, v.exp_a);
        chk({v.name, ":count_b"}, count_b, v.exp_b);
        chk({v.name, ":ovf_b"}, ovf_b, v.ovf_b);
        chk({v.name, ":count_c"}, count_c, v.exp_c);
        chk({v.name, ":ovf_a"}, ovf_a, 0);
        chk({v.name, ":valid_a"}, valid_a, 1);
        chk({v.name, ":busy_len_a"}, busy_cyc[0], G_A);
        chk({v.name, ":busy_len_b"}, busy_cyc[1], G_B);
        chk({v.name, ":busy_len_c"}, busy_cyc[2], G_C);
    endtask

    initial begin
        bit dropped;
        bit o;
        bit c;
        int ph;
        int hi_len;
        int lo_len;

        // name, period, first rise (t rel. to start), held high, a, b, ovf_b, c
        vecs[0] = '{"nominal",  10,  5, 1'b0, 10, 15, 1'b1, 6};
        vecs[1] = '{"static",   10,  0, 1'b1,  0,  0, 1'b0, 0};
        vecs[2] = '{"sat8",      8,  2, 1'b0, 13, 15, 1'b1, 8};
        vecs[3] = '{"slow50",   50,  3, 1'b0,  2,  4, 1'b0, 2};
        vecs[4] = '{"last_in",  40, 18, 1'b0,  3,  5, 1'b0, 2};
        vecs[5] = '{"last_out", 40, 19, 1'b0,  2,  5, 1'b0, 2};
        vecs[6] = '{"pre_in",   30, -1, 1'b0,  4,  7, 1'b0, 3};
        vecs[7] = '{"pre_out",  30, -2, 1'b0,  3,  6, 1'b0, 2};

        rst        = 1'b1;
        osc_in     = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset:count_a", count_a, 0);
        chk("reset:valid_a", valid_a, 0);
        chk("reset:busy_a", busy_a, 0);
        chk("reset:ovf_a", ovf_a, 0);
        rst = 1'b0;
        model_reset();
        repeat (4) drive(1'b0, 1'b0, 1'b0);

        foreach (vecs[v]) run_vec(vecs[v], -100);

        // Second start mid-window is dropped; windows still end on schedule.
        run_vec(vecs[0], 50);

        // Continuous mode, period 4: 16 edges per 64-cycle window, no gaps.
        dropped = 1'b0;
        for (int t = -8; t <= 420; t++) begin
            drive(((t + 100) % 4) < 2, 1'b0, (t >= 0) && (t < 266));
            if (t >= 0 && t < 320 && !busy_c) dropped = 1'b1;
            if (t > 0 && t <= 320 && (t % 64) == 0) chk("cont:count_c", count_c, 16);
            if (t == 320) chk("cont:busy_c_end", busy_c, 0);
        end
        chk("cont:busy_c_gap", dropped, 0);

        // Reset mid-window: outputs clear at once, no partial result.
        drive(1'b0, 1'b1, 1'b0);
        for (int t = 1; t < 50; t++) drive(((t + 5) % 10) < 5, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst:count_a", count_a, 0);
        chk("midrst:valid_a", valid_a, 0);
        chk("midrst:busy_a", busy_a, 0);
        chk("midrst:ovf_a", ovf_a, 0);
        chk("midrst:valid_b", valid_b, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        osc_in = 1'b0;
        model_reset();
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        run_vec(vecs[0], -100);

        // Random tap waveforms, start pulses and continuous spans.
        o = 1'b0;
        c = 1'b0;
        ph = 0;
        hi_len = 3;
        lo_len = 3;
        for (int t = 0; t < 2750; t++) begin
            if (t % 300 == 0) c = (t < 2500) && ($urandom_range(0, 2) == 0);
            ph++;
            if (o && ph >= hi_len) begin
                o = 1'b0;
                ph = 0;
                lo_len = $urandom_range(2, 12);
            end else if (!o && ph >= lo_len) begin
                o = 1'b1;
                ph = 0;
                hi_len = $urandom_range(2, 12);
            end
            drive(o, ($urandom_range(0, 39) == 0) && (t < 2500), c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
